// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
package fpu_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_rr_arb.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to ~last.
module fpu_rr_arb
  import fpu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               last,
  output logic [NUM_REQ-1:0] grant
);

  // One-hot grant from the request vector and last-grant pointer
  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/fsub.sv
// Combinational IEEE-754 single-precision subtractor y = x1 - x2, round to nearest even.
// ovf flags a finite result that rounded beyond the largest normal (y becomes infinity).
module fsub (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);

  logic [31:0] a, b, big, sml;
  logic        a_nan, b_nan, a_inf, b_inf, eff_sub;
  logic [8:0]  e_big, e_sml, d;
  logic [26:0] m_big, m_sml, m_sh, lost_mask, nrm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic        lz_found, rnd_up;
  logic [9:0]  e_n;
  logic [24:0] rnd;

  // Align, add magnitudes, normalise, round and pack
  always_comb begin
    a         = x1;
    b         = {~x2[31], x2[30:0]};
    a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf     = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf     = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    big       = a;
    sml       = b;
    lost_mask = '0;
    m_sh      = '0;
    lz        = '0;
    lz_found  = 1'b0;
    nrm       = '0;
    e_n       = '0;
    y         = '0;
    ovf       = 1'b0;

    if (b[30:0] > a[30:0]) begin
      big = b;
      sml = a;
    end
    eff_sub = big[31] ^ sml[31];
    // Denormals share the exponent of the smallest normal
    e_big   = (big[30:23] == 8'd0) ? 9'd1 : {1'b0, big[30:23]};
    e_sml   = (sml[30:23] == 8'd0) ? 9'd1 : {1'b0, sml[30:23]};
    m_big   = {(big[30:23] != 8'd0), big[22:0], 3'b000};
    m_sml   = {(sml[30:23] != 8'd0), sml[22:0], 3'b000};
    d       = e_big - e_sml;

    // Three guard bits; everything shifted past them collapses into bit 0
    if (d >= 9'd27) begin
      m_sh = {26'd0, |m_sml};
    end else begin
      lost_mask = (27'd1 << d[4:0]) - 27'd1;
      m_sh      = (m_sml >> d[4:0]) | {26'd0, |(m_sml & lost_mask)};
    end

    sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_sh}) : ({1'b0, m_big} + {1'b0, m_sh});

    for (int k = 26; k >= 0; k--) begin
      if (!lz_found) begin
        if (sum[k]) lz_found = 1'b1;
        else        lz = lz + 5'd1;
      end
    end

    if (sum[27]) begin
      nrm = {sum[27:2], sum[1] | sum[0]};
      e_n = {1'b0, e_big} + 10'd1;
    end else if ({4'd0, lz} < e_big) begin
      nrm = sum[26:0] << lz;
      e_n = {1'b0, e_big} - {5'd0, lz};
    end else begin
      // Cannot normalise fully: result is denormal
      nrm = sum[26:0] << (e_big - 9'd1);
      e_n = 10'd1;
    end

    rnd_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    rnd    = {1'b0, nrm[26:3]} + {24'd0, rnd_up};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e_n = e_n + 10'd1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
      y = 32'h7FC0_0000;
    end else if (a_inf) begin
      y = {a[31], 8'hFF, 23'd0};
    end else if (b_inf) begin
      y = {b[31], 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      // Exact cancellation gives +0; -0 only from two negative zeros
      y = {big[31] & ~eff_sub, 31'd0};
    end else if (e_n >= 10'd255) begin
      y   = {big[31], 8'hFF, 23'd0};
      ovf = 1'b1;
    end else begin
      y = {big[31], (rnd[23] ? e_n[7:0] : 8'h00), rnd[22:0]};
    end
  end

endmodule

// File: rtl/fpu_addsub_arb.sv
// Two requesters share one fsub datapath: IDLE accepts, EXEC registers the result, DONE
// presents it until the consumer takes it. Fixed 2-cycle latency, one op per 3 cycles.
// Optional: define FPU_ARB_OVF_STICKY_EN for the sticky overflow status bit.
module fpu_addsub_arb
  import fpu_arb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_op,
  input  logic [NUM_REQ-1:0][31:0] req_x1,
  input  logic [NUM_REQ-1:0][31:0] req_x2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_id,
  output logic [31:0]              out_y,
  output logic                     out_ovf,
  input  logic                     ovf_clr,
  output logic                     ovf_sticky
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic               accept, acc_id, last_q;
  logic               op_q, id_q;
  logic [31:0]        x1_q, x2_q, x2_eff, fsub_y;
  logic               fsub_ovf;

  fpu_rr_arb u_rr_arb (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  assign accept = (state_q == IDLE) && ((req_valid & grant) != '0);
  assign acc_id = grant[1];

  // Add is issued as a subtract of the negated second operand
  assign x2_eff = (op_q == OP_SUB) ? x2_q : {~x2_q[31], x2_q[30:0]};

  fsub u_fsub (
    .x1  (x1_q),
    .x2  (x2_eff),
    .y   (fsub_y),
    .ovf (fsub_ovf)
  );

  // Next state and handshake strobes
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand capture on acceptance, result capture in EXEC
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q    <= OP_ADD;
      x1_q    <= '0;
      x2_q    <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      out_y   <= '0;
      out_ovf <= 1'b0;
      out_id  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= req_op[acc_id];
        x1_q   <= req_x1[acc_id];
        x2_q   <= req_x2[acc_id];
        id_q   <= acc_id;
        last_q <= acc_id;
      end
      if (state_q == EXEC) begin
        out_y   <= fsub_y;
        out_ovf <= fsub_ovf;
        out_id  <= id_q;
      end
    end
  end

`ifdef FPU_ARB_OVF_STICKY_EN
  logic sticky_q;

  // Set on handing off an overflowed result; set beats a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              sticky_q <= 1'b0;
    else if (out_valid && out_ready && out_ovf) sticky_q <= 1'b1;
    else if (ovf_clr)                       sticky_q <= 1'b0;
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: doc/fpu_addsub_arb.md
FPU_ADDSUB_ARB -- requirements
Module: fpu_addsub_arb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have ports req_valid, input, 2 bits: per-requester request valid (bit i = requester i).
REQ-004 SHALL have ports req_ready, output, 2 bits: per-requester accept strobe.
REQ-005 SHALL have ports req_op, input, 2 bits: per-requester operation, 0 = add (x1+x2), 1 = sub (x1-x2).
REQ-006 SHALL have ports req_x1 and req_x2, input, 2x32 bits each: per-requester IEEE-754 single operands.
REQ-007 SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-009 SHALL have ports out_id (1 bit), out_y (32 bits) and out_ovf (1 bit), outputs: requester index, result, and overflow flag from the shared datapath.
REQ-010 SHALL have ports ovf_clr (input, 1 bit) and ovf_sticky (output, 1 bit): sticky-overflow clear and status.

Function
REQ-011 SHALL share one fsub datapath instance between both requesters; add SHALL be issued as fsub(x1, {~x2[31], x2[30:0]}).
REQ-012 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-013 In IDLE, req_ready[i] SHALL be 1 only for the granted requester, and only when its req_valid[i]=1. Acceptance is req_valid[i] & req_ready[i].
REQ-014 On acceptance, the FSM SHALL latch op, x1, x2 and id into operand registers and move to EXEC.
REQ-015 In EXEC, the FSM SHALL register the fsub outputs y and ovf into out_y and out_ovf, then move to DONE. The result path is therefore exactly one register stage.
REQ-016 In DONE, out_valid SHALL be 1. The FSM SHALL hold out_y, out_ovf and out_id stable until out_valid & out_ready, then return to IDLE.
REQ-017 Latency SHALL be fixed: acceptance at cycle N gives out_valid=1 at cycle N+2. Peak throughput SHALL be one operation per 3 cycles.
REQ-018 req_ready SHALL be 2'b00 in EXEC and DONE; no acceptance outside IDLE.
REQ-019 Arbitration SHALL be round-robin with a 1-bit last-grant pointer:
- only one requester valid: grant it;
- both valid: grant ~last;
- the pointer SHALL update only on acceptance.
REQ-020 If out_ready stays low, the FSM SHALL remain in DONE indefinitely, with no new acceptance and no output change.
REQ-021 A requester deasserting req_valid while not granted SHALL have no effect. Operands SHALL be sampled only at acceptance.
REQ-022 out_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-023 Asserting rstn=0 SHALL immediately force:
- FSM to IDLE;
- out_valid=0, out_y=0, out_ovf=0, out_id=0;
- last-grant pointer to 1, so that requester 0 wins the first tie;
- ovf_sticky=0.
REQ-024 Reset during EXEC or DONE SHALL discard the in-flight operation; no result SHALL be delivered after reset release.

Configuration
REQ-025 Macro FPU_ARB_OVF_STICKY_EN SHALL control the sticky overflow feature.
- Defined: ovf_sticky SHALL set on any cycle in which a result with out_ovf=1 is handed off, and SHALL clear on ovf_clr=1. If set and clear occur in the same cycle, set SHALL win.
- Undefined: ovf_sticky SHALL be tied to 0, ovf_clr SHALL be ignored, and no register SHALL be inferred.

Structure
REQ-026 Package fpu_arb_pkg SHALL hold:
- the FSM state enum (IDLE, EXEC, DONE);
- constants OP_ADD=0 and OP_SUB=1;
- NUM_REQ=2.
REQ-027 Round-robin grant logic SHALL be a sub-module named fpu_rr_arb (inputs valid[1:0] and last; output grant[1:0]). fsub SHALL be instantiated unmodified.

Verification
REQ-028 Requester 0 add, x1=0x3F800000, x2=0x40000000 → out_y=0x40400000, out_id=0, out_ovf=0, out_valid exactly 2 cycles after acceptance.
REQ-029 Requester 1 sub, x1=0x40400000, x2=0x3F800000 → out_y=0x40000000, out_id=1.
REQ-030 Both requesters valid continuously from reset, 4 operations → grant order 0,1,0,1 and out_id sequence 0,1,0,1.
REQ-031 Add 0x7F7FFFFF + 0x7F7FFFFF → out_ovf=1. With FPU_ARB_OVF_STICKY_EN defined, ovf_sticky=1 until ovf_clr pulses; without the macro, ovf_sticky stays 0.
REQ-032 out_ready held low for 10 cycles in DONE → out_y stable, req_ready=2'b00 throughout; handshake on cycle 11 returns the FSM to IDLE.
REQ-033 rstn pulsed low during EXEC → out_valid stays 0 and the next request is granted to requester 0 on a tie.
